// File: rtl/rx_anc_sync_seq.sv
// RX ANC sync/timing controller: synchronised GPIO trigger, NUM_SEG-segment sync sequence,
// and a sample-gated symbol-hopping phase generator for the downstream mixers.
module rx_anc_sync_seq #(
    parameter int PHASE_WIDTH    = 24,
    parameter int NSYMB_WIDTH    = 16,
    parameter int CNT_WIDTH      = 16,
    parameter int NUM_SEG        = 4,
    parameter int SEG_LEN        = 8192,
    parameter logic [7:0] START_MASK = 8'h06,
    parameter logic [7:0] MUX_MASK   = 8'h06,
    parameter int NSIG           = 16384,
    parameter int NSYMB          = 512,
    parameter int START_PH_INC   = 4096,
    parameter int DPH_INC        = 16384,
    parameter int NHT_PH_INC     = 12288,
    parameter int ANC_PH_INC     = 2048,
    parameter int START_PH       = 0,
    parameter int GPIO_REG_WIDTH = 12,
    parameter int TRIG_BIT       = 2,
    parameter logic [GPIO_REG_WIDTH-1:0] GPIO_OUT_MASK = 12'h011
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [GPIO_REG_WIDTH-1:0] gpio_in,
    input  logic                      abort,
    input  logic                      sample_tvalid,
    output logic [GPIO_REG_WIDTH-1:0] gpio_out,
    output logic                      rx_valid,
    output logic                      rx_start,
    output logic                      out_sel,
    output logic [2:0]                seg_idx,
    output logic                      busy,
    output logic                      done,
    output logic [PHASE_WIDTH-1:0]    ph_nht,
    output logic [PHASE_WIDTH-1:0]    ph_bb,
    output logic [PHASE_WIDTH-1:0]    ph_fshift,
    output logic [PHASE_WIDTH-1:0]    ph_bb_inc,
    output logic [NSYMB_WIDTH-1:0]    symb_idx,
    output logic                      symb_start
);
    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] RUN  = 1'b1;

    localparam logic [CNT_WIDTH-1:0]   SEG_LAST  = CNT_WIDTH'(SEG_LEN - 1);
    localparam logic [2:0]             IDX_LAST  = 3'(NUM_SEG - 1);
    localparam logic [CNT_WIDTH-1:0]   NSIG_C    = CNT_WIDTH'(NSIG);
    localparam logic [NSYMB_WIDTH-1:0] NSYMB_C   = NSYMB_WIDTH'(NSYMB);
    localparam logic [PHASE_WIDTH-1:0] PH0       = PHASE_WIDTH'(START_PH);
    localparam logic [PHASE_WIDTH-1:0] INC0      = PHASE_WIDTH'(START_PH_INC);
    localparam logic [PHASE_WIDTH-1:0] DPH_C     = PHASE_WIDTH'(DPH_INC);
    localparam logic [PHASE_WIDTH-1:0] NHT_C     = PHASE_WIDTH'(NHT_PH_INC);
    localparam logic [PHASE_WIDTH-1:0] ANC_C     = PHASE_WIDTH'(ANC_PH_INC);

    logic [0:0]           state, state_nx;
    logic [2:0]           seg_idx_nx;
    logic [CNT_WIDTH-1:0] seg_cnt, seg_cnt_nx, sig_cnt;
    logic                 rx_valid_nx, done_nx;
    logic [2:0]           trig_sync;
    logic                 trig_rise, run_nx, ph_hold;

    // Sync flops reset high so a trigger level already present at reset release is not an edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) trig_sync <= 3'b111;
        else       trig_sync <= {trig_sync[1:0], gpio_in[TRIG_BIT]};
    end
    assign trig_rise = trig_sync[1] & ~trig_sync[2];

    always_comb begin
        state_nx    = state;
        seg_idx_nx  = seg_idx;
        seg_cnt_nx  = seg_cnt;
        rx_valid_nx = rx_valid;
        done_nx     = 1'b0;
        if (abort) begin
            state_nx    = IDLE;
            seg_idx_nx  = '0;
            seg_cnt_nx  = '0;
            rx_valid_nx = 1'b0;
        end else if (state == IDLE) begin
            if (trig_rise) begin
                state_nx    = RUN;
                rx_valid_nx = 1'b1;
                seg_idx_nx  = '0;
                seg_cnt_nx  = '0;
            end
        end else if (seg_cnt == SEG_LAST) begin
            seg_cnt_nx = '0;
            if (seg_idx == IDX_LAST) begin
                state_nx   = IDLE;
                done_nx    = 1'b1;
                seg_idx_nx = '0;
            end else begin
                seg_idx_nx = seg_idx + 3'd1;
            end
        end else begin
            seg_cnt_nx = seg_cnt + 1'b1;
        end
    end

    assign run_nx = (state_nx == RUN);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            seg_idx  <= '0;
            seg_cnt  <= '0;
            rx_valid <= 1'b0;
            done     <= 1'b0;
            rx_start <= 1'b0;
            out_sel  <= 1'b0;
        end else begin
            state    <= state_nx;
            seg_idx  <= seg_idx_nx;
            seg_cnt  <= seg_cnt_nx;
            rx_valid <= rx_valid_nx;
            done     <= done_nx;
            // Levels follow the next-state segment so they switch together with seg_idx.
            rx_start <= run_nx & START_MASK[seg_idx_nx];
            out_sel  <= run_nx & MUX_MASK[seg_idx_nx];
        end
    end

    assign busy     = (state == RUN);
    assign gpio_out = rx_valid ? GPIO_OUT_MASK : '0;
    assign ph_hold  = rx_start | abort;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sig_cnt    <= NSIG_C;
            symb_idx   <= NSYMB_C;
            ph_nht     <= PH0;
            ph_bb      <= PH0;
            ph_fshift  <= PH0;
            ph_bb_inc  <= INC0;
            symb_start <= 1'b0;
        end else begin
            symb_start <= 1'b0;
            if (ph_hold) begin
                sig_cnt   <= NSIG_C;
                symb_idx  <= NSYMB_C;
                ph_nht    <= PH0;
                ph_bb     <= PH0;
                ph_fshift <= PH0;
                ph_bb_inc <= INC0;
            end else if (sample_tvalid) begin
                if (sig_cnt == NSIG_C) begin
                    sig_cnt    <= CNT_WIDTH'(1);
                    ph_nht     <= PH0;
                    ph_bb      <= PH0;
                    ph_fshift  <= PH0;
                    symb_start <= 1'b1;
                    if (symb_idx == NSYMB_C) begin
                        symb_idx  <= NSYMB_WIDTH'(1);
                        ph_bb_inc <= INC0;
                    end else begin
                        symb_idx  <= symb_idx + 1'b1;
                        ph_bb_inc <= ph_bb_inc + DPH_C;
                    end
                end else begin
                    sig_cnt   <= sig_cnt + 1'b1;
                    ph_nht    <= ph_nht - NHT_C;
                    ph_bb     <= ph_bb - ph_bb_inc;
                    ph_fshift <= ph_fshift + ANC_C + ph_bb_inc;
                end
            end
        end
    end
endmodule

// File: tb/tb_rx_anc_sync_seq.sv
// Scoreboard bench for rx_anc_sync_seq: stimulus queues cycle-tagged expectations, a monitor checks them.
module tb_rx_anc_sync_seq;
    localparam int S_BUSY = 0, S_VALID = 1, S_SEG = 2, S_START = 3, S_SEL = 4, S_DONE = 5,
                   S_GPIO = 6, S_NHT = 7, S_BB = 8, S_FS = 9, S_INC = 10, S_SYMB = 11, S_SS = 12;

    logic        clk = 1'b0, reset = 1'b1, abort = 1'b0, sample_tvalid = 1'b0;
    logic [11:0] gpio_in = '0;
    logic [11:0] gpio_out;
    logic        rx_valid, rx_start, out_sel, busy, done, symb_start;
    logic [2:0]  seg_idx;
    logic [23:0] ph_nht, ph_bb, ph_fshift, ph_bb_inc;
    logic [15:0] symb_idx;

    rx_anc_sync_seq #(.NUM_SEG(4), .SEG_LEN(8), .START_MASK(8'h06), .MUX_MASK(8'h06),
                      .NSIG(4), .NSYMB(3)) dut (
        .clk(clk), .reset(reset), .gpio_in(gpio_in), .abort(abort), .sample_tvalid(sample_tvalid),
        .gpio_out(gpio_out), .rx_valid(rx_valid), .rx_start(rx_start), .out_sel(out_sel),
        .seg_idx(seg_idx), .busy(busy), .done(done), .ph_nht(ph_nht), .ph_bb(ph_bb),
        .ph_fshift(ph_fshift), .ph_bb_inc(ph_bb_inc), .symb_idx(symb_idx), .symb_start(symb_start));

    always #5 clk = ~clk;

    typedef struct { int cyc; int sel; logic [31:0] v; } exp_t;
    exp_t  q[$];
    int    cyc = 0, total = 0, bad = 0;
    string names[13] = '{"busy", "rx_valid", "seg_idx", "rx_start", "out_sel", "done", "gpio_out",
                         "ph_nht", "ph_bb", "ph_fshift", "ph_bb_inc", "symb_idx", "symb_start"};

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] get_sig(input int sel);
        case (sel)
            S_BUSY:  return 32'(busy);
            S_VALID: return 32'(rx_valid);
            S_SEG:   return 32'(seg_idx);
            S_START: return 32'(rx_start);
            S_SEL:   return 32'(out_sel);
            S_DONE:  return 32'(done);
            S_GPIO:  return 32'(gpio_out);
            S_NHT:   return 32'(ph_nht);
            S_BB:    return 32'(ph_bb);
            S_FS:    return 32'(ph_fshift);
            S_INC:   return 32'(ph_bb_inc);
            S_SYMB:  return 32'(symb_idx);
            S_SS:    return 32'(symb_start);
            default: return '0;
        endcase
    endfunction

    task automatic expect_at(input int c, input int sel, input logic [31:0] v);
        exp_t e;
        int   i = 0;
        e.cyc = c; e.sel = sel; e.v = v;
        while (i < q.size() && q[i].cyc <= c) i++;
        q.insert(i, e);
    endtask

    task automatic check_now(input int sel, input logic [31:0] v);
        logic [31:0] act;
        act = get_sig(sel);
        total++;
        if (act !== v) begin
            bad++;
            $display("FAIL async_%s got=%h want=%h", names[sel], act, v);
        end
    endtask

    task automatic wait_cyc(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    // Monitor: compare every expectation whose cycle tag has come due.
    always @(negedge clk) begin
        exp_t        e;
        logic [31:0] act;
        while (q.size() > 0 && q[0].cyc <= cyc) begin
            e = q.pop_front();
            act = get_sig(e.sel);
            total++;
            if (e.cyc != cyc || act !== e.v) begin
                bad++;
                $display("FAIL %s cyc=%0d tag=%0d got=%h want=%h", names[e.sel], cyc, e.cyc, act, e.v);
            end
        end
    end

    initial begin
        #50000;
        $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        int n, b, p;
        @(negedge clk); @(negedge clk); @(negedge clk);
        // reset state
        expect_at(cyc + 1, S_BUSY, 0);  expect_at(cyc + 1, S_VALID, 0);
        expect_at(cyc + 1, S_SYMB, 3);  expect_at(cyc + 1, S_INC, 4096);
        expect_at(cyc + 1, S_GPIO, 0);  expect_at(cyc + 1, S_BB, 0);
        expect_at(cyc + 1, S_DONE, 0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);

        // trigger timing and segment stepping
        n = cyc; b = n + 3; gpio_in[2] = 1'b1;
        expect_at(b - 1, S_BUSY, 0);
        expect_at(b, S_BUSY, 1);  expect_at(b, S_VALID, 1); expect_at(b, S_SEG, 0);
        expect_at(b, S_GPIO, 32'h011); expect_at(b, S_START, 0);
        expect_at(b + 7, S_SEG, 0);  expect_at(b + 7, S_START, 0);
        expect_at(b + 8, S_SEG, 1);  expect_at(b + 8, S_START, 1); expect_at(b + 8, S_SEL, 1);
        expect_at(b + 16, S_SEG, 2); expect_at(b + 16, S_START, 1);
        expect_at(b + 23, S_SEG, 2); expect_at(b + 23, S_SEL, 1);
        expect_at(b + 24, S_SEG, 3); expect_at(b + 24, S_START, 0); expect_at(b + 24, S_SEL, 0);
        expect_at(b + 31, S_BUSY, 1); expect_at(b + 31, S_DONE, 0);
        expect_at(b + 32, S_BUSY, 0); expect_at(b + 32, S_DONE, 1); expect_at(b + 32, S_SEG, 0);
        expect_at(b + 33, S_DONE, 0); expect_at(b + 33, S_VALID, 1); expect_at(b + 33, S_GPIO, 32'h011);
        repeat (3) @(negedge clk);
        gpio_in[2] = 1'b0;
        wait_cyc(b + 36);

        // retrigger while busy is ignored
        n = cyc; b = n + 3; gpio_in[2] = 1'b1;
        expect_at(b, S_BUSY, 1);
        expect_at(b + 10, S_SEG, 1); expect_at(b + 11, S_SEG, 1);
        expect_at(b + 20, S_DONE, 0);
        expect_at(b + 31, S_BUSY, 1);
        expect_at(b + 32, S_BUSY, 0); expect_at(b + 32, S_DONE, 1);
        expect_at(b + 33, S_DONE, 0);
        repeat (3) @(negedge clk);
        gpio_in[2] = 1'b0;
        wait_cyc(b + 7);
        gpio_in[2] = 1'b1;
        repeat (3) @(negedge clk);
        gpio_in[2] = 1'b0;
        wait_cyc(b + 36);

        // phase stepping with continuous samples
        p = cyc; sample_tvalid = 1'b1;
        expect_at(p + 1, S_SS, 1); expect_at(p + 1, S_SYMB, 1); expect_at(p + 1, S_INC, 4096);
        expect_at(p + 1, S_BB, 0);
        expect_at(p + 2, S_BB, 32'hFFF000); expect_at(p + 2, S_FS, 6144);
        expect_at(p + 2, S_NHT, 32'hFFD000); expect_at(p + 2, S_SS, 0);
        expect_at(p + 3, S_BB, 32'hFFE000); expect_at(p + 3, S_FS, 12288);
        expect_at(p + 4, S_BB, 32'hFFD000); expect_at(p + 4, S_FS, 18432);
        expect_at(p + 4, S_NHT, 32'hFF7000);
        expect_at(p + 5, S_SS, 1); expect_at(p + 5, S_SYMB, 2); expect_at(p + 5, S_INC, 20480);
        expect_at(p + 5, S_BB, 0); expect_at(p + 5, S_FS, 0);
        expect_at(p + 6, S_BB, 32'hFFB000); expect_at(p + 6, S_FS, 22528);
        expect_at(p + 9, S_SYMB, 3); expect_at(p + 9, S_INC, 36864); expect_at(p + 9, S_SS, 1);
        expect_at(p + 13, S_SYMB, 1); expect_at(p + 13, S_INC, 4096); expect_at(p + 13, S_SS, 1);
        expect_at(p + 14, S_BB, 32'hFFF000); expect_at(p + 14, S_SS, 0);
        wait_cyc(p + 14);
        sample_tvalid = 1'b0;

        // sample gating: state only moves on valid cycles
        p = cyc;
        expect_at(p + 1, S_BB, 32'hFFE000); expect_at(p + 1, S_FS, 12288);
        expect_at(p + 1, S_NHT, 32'hFFA000);
        expect_at(p + 2, S_BB, 32'hFFE000); expect_at(p + 2, S_FS, 12288); expect_at(p + 2, S_SYMB, 1);
        expect_at(p + 3, S_BB, 32'hFFD000); expect_at(p + 3, S_FS, 18432);
        expect_at(p + 4, S_BB, 32'hFFD000); expect_at(p + 4, S_SS, 0);
        expect_at(p + 6, S_SS, 1); expect_at(p + 6, S_SYMB, 2); expect_at(p + 6, S_INC, 20480);
        expect_at(p + 6, S_BB, 0);
        expect_at(p + 7, S_SS, 0); expect_at(p + 7, S_SYMB, 2);
        sample_tvalid = 1'b1; @(negedge clk);
        sample_tvalid = 1'b0; @(negedge clk);
        sample_tvalid = 1'b1; @(negedge clk);
        sample_tvalid = 1'b0;
        wait_cyc(p + 5);
        sample_tvalid = 1'b1; @(negedge clk);
        sample_tvalid = 1'b0;
        wait_cyc(p + 9);

        // abort mid-sequence, then a fresh full sequence
        n = cyc; b = n + 3; gpio_in[2] = 1'b1;
        expect_at(b + 11, S_BUSY, 1); expect_at(b + 11, S_START, 1);
        expect_at(b + 12, S_BUSY, 0); expect_at(b + 12, S_VALID, 0); expect_at(b + 12, S_GPIO, 0);
        expect_at(b + 12, S_START, 0); expect_at(b + 12, S_SEL, 0); expect_at(b + 12, S_DONE, 0);
        expect_at(b + 12, S_BB, 0); expect_at(b + 12, S_SYMB, 3); expect_at(b + 12, S_INC, 4096);
        expect_at(b + 13, S_BUSY, 0); expect_at(b + 13, S_DONE, 0);
        repeat (3) @(negedge clk);
        gpio_in[2] = 1'b0;
        wait_cyc(b + 11);
        abort = 1'b1; @(negedge clk);
        abort = 1'b0;
        wait_cyc(b + 16);
        n = cyc; b = n + 3; gpio_in[2] = 1'b1;
        expect_at(b - 1, S_BUSY, 0); expect_at(b, S_BUSY, 1); expect_at(b, S_VALID, 1);
        expect_at(b + 31, S_BUSY, 1);
        expect_at(b + 32, S_BUSY, 0); expect_at(b + 32, S_DONE, 1);
        repeat (3) @(negedge clk);
        gpio_in[2] = 1'b0;
        wait_cyc(b + 36);

        // asynchronous reset mid-sequence with the trigger level held high through release
        n = cyc; b = n + 3; gpio_in[2] = 1'b1;
        expect_at(b + 19, S_BUSY, 1); expect_at(b + 19, S_START, 1);
        wait_cyc(b + 20);
        #2 reset = 1'b1;
        #1;
        check_now(S_BUSY, 0);  check_now(S_VALID, 0); check_now(S_SEG, 0);
        check_now(S_START, 0); check_now(S_GPIO, 0);  check_now(S_SYMB, 3);
        check_now(S_INC, 4096);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        expect_at(cyc + 2, S_BUSY, 0); expect_at(cyc + 5, S_BUSY, 0);
        expect_at(cyc + 8, S_BUSY, 0); expect_at(cyc + 8, S_VALID, 0);
        wait_cyc(cyc + 10);
        gpio_in[2] = 1'b0;

        repeat (50) if (q.size() > 0) @(negedge clk);
        while (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            total++; bad++;
            $display("FAIL %s never_checked tag=%0d want=%h", names[e.sel], e.cyc, e.v);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/rx_anc_sync_seq.md
Name: rx_anc_sync_seq

Overview:
- Parametrised successor of the RX ANC sync/timing controller.
- Synchronises a front-panel GPIO trigger and runs a programmable NUM_SEG-segment sync sequence.
- Drives per-segment start (phase-hold) and output-mux levels, and generates symbol-hopping phase words for the downstream freq_shift_and_lpf_iq / freq_shift_iq / cmul stages.
- Compared with the previous generation, it adds: segment count and masks as parameters, sample-gated phase advance, a software abort, and a done pulse.

Parameters:
- PHASE_WIDTH, 24, width of all phase words and increments.
- NSYMB_WIDTH, 16, width of the symbol counter.
- CNT_WIDTH, 16, width of the segment and sample counters.
- NUM_SEG, 4, number of sync segments (legal range 2..8).
- SEG_LEN, 8192, clock cycles per segment.
- START_MASK, 8'h06, bit i set = rx_start high during segment i.
- MUX_MASK, 8'h06, bit i = out_sel level during segment i.
- NSIG, 16384, accepted samples per symbol.
- NSYMB, 512, symbols per hop cycle.
- START_PH_INC, 4096, baseband increment for symbol 1.
- DPH_INC, 16384, baseband increment step per symbol.
- NHT_PH_INC, 12288, fixed NHT phase increment.
- ANC_PH_INC, 2048, fixed ANC offset added to the fshift increment.
- START_PH, 0, phase reload value.
- GPIO_REG_WIDTH, 12, GPIO register width.
- TRIG_BIT, 2, gpio_in bit used as the trigger.
- GPIO_OUT_MASK, 12'h011, bits driven high on gpio_out while rx_valid.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- gpio_in  in  GPIO_REG_WIDTH  GPIO input register
- abort  in  1  synchronous abort: return to IDLE and clear rx_valid
- sample_tvalid  in  1  one accepted RX sample this cycle; advances the phase generator
- gpio_out  out  GPIO_REG_WIDTH  GPIO_OUT_MASK when rx_valid, else 0
- rx_valid  out  1  sticky "sequence triggered" flag
- rx_start  out  1  START_MASK[seg_idx] while busy, else 0
- out_sel  out  1  MUX_MASK[seg_idx] while busy, else 0
- seg_idx  out  3  current segment index
- busy  out  1  sequence running
- done  out  1  one-cycle pulse at sequence end
- ph_nht, ph_bb, ph_fshift  out  PHASE_WIDTH  phase words
- ph_bb_inc  out  PHASE_WIDTH  current baseband increment
- symb_idx  out  NSYMB_WIDTH  current symbol number, 1..NSYMB
- symb_start  out  1  pulse on the first sample of each symbol

Behaviour:
- Reset (asynchronous) values: all outputs 0 except symb_idx=NSYMB; internal sig_cnt=NSIG; ph_*=START_PH; ph_bb_inc=START_PH_INC; state IDLE.
- Trigger path:
  - gpio_in[TRIG_BIT] passes through a 2-flop synchroniser, then a rising-edge detector (3rd flop).
  - An edge is accepted only in IDLE; edges while busy are ignored.
  - A level already high at reset release is not a trigger.
- FSM IDLE -> RUN -> IDLE:
  - On an accepted edge at cycle T: at T+1, busy=1, rx_valid=1, seg_idx=0, seg_cnt=0.
  - In RUN, seg_cnt increments each clock.
  - At seg_cnt==SEG_LEN-1: seg_cnt<=0 and seg_idx<=seg_idx+1.
  - If seg_idx==NUM_SEG-1 at that point: go to IDLE, busy=0, done=1 for one cycle, seg_idx<=0.
  - Each segment therefore lasts exactly SEG_LEN cycles; the full sequence lasts NUM_SEG*SEG_LEN cycles.
- rx_start and out_sel are registered, derived from the next-state seg_idx, so they change in the same cycle as seg_idx.
- rx_valid stays set after the sequence completes; only reset or abort clears it.
- abort (highest priority after reset): next cycle IDLE, busy=0, rx_valid=0, rx_start=0, out_sel=0, done=0, phase generator reloaded. An abort and a trigger in the same cycle: abort wins.
- Phase generator (all arithmetic modulo 2^PHASE_WIDTH):
  - Hold: while rx_start=1 or abort, load sig_cnt=NSIG, symb_idx=NSYMB, ph_*=START_PH, ph_bb_inc=START_PH_INC.
  - Otherwise the generator changes only on cycles with sample_tvalid=1.
  - On an advance with sig_cnt==NSIG (symbol boundary):
    - sig_cnt<=1, ph_*<=START_PH, symb_start=1.
    - If symb_idx==NSYMB: symb_idx<=1 and ph_bb_inc<=START_PH_INC.
    - Else: symb_idx+1 and ph_bb_inc+=DPH_INC.
  - On any other advance: sig_cnt+1; ph_nht-=NHT_PH_INC; ph_bb-=ph_bb_inc; ph_fshift+=ANC_PH_INC+ph_bb_inc.
  - symb_start is a registered pulse, 0 on all other cycles.
  - The generator also runs in IDLE, with no gating by busy.
- Reset asserted mid-sequence: immediate return to the reset values listed above.

Test Plan:
- Parameters for all scenarios: NUM_SEG=4, SEG_LEN=8, START_MASK=MUX_MASK=4'b0110, NSIG=4, NSYMB=3.
- Trigger timing: pulse gpio_in[2] high for 3 cycles -> busy rises 3 cycles after the edge (2 sync + 1 edge + FSM); seg_idx steps 0,1,2,3 every 8 cycles; rx_start=out_sel=1 exactly during segments 1-2 (16 cycles); done pulses once after 32 busy cycles; gpio_out=12'h011 from the trigger onward and stays set.
- Retrigger while busy: second edge at busy cycle 10 -> no restart; total busy length still 32; done pulses once.
- Phase stepping: sample_tvalid held 1 with rx_start=0 -> symbol 1: ph_bb_inc=4096, ph_bb=0, -4096, -8192, -12288 mod 2^24 (0xFFF000, 0xFFE000, 0xFFD000); ph_fshift=0, 6144, 12288, 18432; symbol 2: ph_bb_inc=20480; symbol 4 wraps to symb_idx=1, inc=4096; symb_start pulses every 4 samples.
- Sample gating: sample_tvalid toggled 1,0,1,0 -> phases change only on valid cycles; sig_cnt and symb_idx are unchanged on idle cycles.
- Abort: assert abort at busy cycle 12 -> next cycle busy=0, rx_valid=0, gpio_out=0, phases=START_PH; a new trigger afterwards starts a full 32-cycle sequence.
- Asynchronous reset mid-sequence: reset at busy cycle 20, asserted between clock edges -> outputs go to their reset values without waiting for a clock edge; trigger level held high through reset release -> no sequence starts.
